// File: rtl/bus_rr_arbiter.sv
// Packet bus arbiter: pops one packet from a pending device, decodes its destination ID and
// pushes it to one device, or to every other device on broadcast. Define BUS_STATS_EN for pkt_cnt.
module bus_rr_arbiter #(
  parameter int              DRVRS     = 6,
  parameter int              PCKG_SZ   = 16,
  parameter int              ID_W      = 8,
  parameter logic [ID_W-1:0] BROADCAST = 8'hFF,
  parameter int              ARB_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         pndng,
  input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
  output logic [DRVRS-1:0]         pop,
  output logic [DRVRS-1:0]         push,
  output logic [PCKG_SZ-1:0]       D_push,
  output logic                     busy,
`ifdef BUS_STATS_EN
  output logic [31:0]              pkt_cnt,
`endif
  output logic                     err_drop
);

  localparam int IDX_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam logic [DRVRS-1:0] ONE_HOT0 = {{(DRVRS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   win_r;
  logic [PCKG_SZ-1:0] data_q_r;
  logic [DRVRS-1:0]   pop_r;
  logic [DRVRS-1:0]   push_r;
  logic [PCKG_SZ-1:0] d_push_r;
  logic               busy_r;
  logic               err_drop_r;
`ifdef BUS_STATS_EN
  logic [31:0]        pkt_cnt_r;
`endif

  logic [IDX_W-1:0]   win_s;
  logic [IDX_W-1:0]   cand_idx_s;
  logic               found_s;
  int                 cand_s;
  logic [ID_W-1:0]    dest_s;
  logic [31:0]        dest_ext_s;
  logic [DRVRS-1:0]   push_mask_s;
  logic               drop_s;
  logic [IDX_W-1:0]   next_ptr_s;

  // Winner search: rotate from rr_ptr in round-robin mode, from index 0 in fixed-priority mode
  always_comb begin
    win_s      = '0;
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int i = 0; i < DRVRS; i++) begin
      if (ARB_MODE == 1) begin
        cand_s = i;
      end else begin
        cand_s = int'(rr_ptr_r) + i;
        if (cand_s >= DRVRS) begin
          cand_s = cand_s - DRVRS;
        end else begin
          cand_s = cand_s;
        end
      end
      cand_idx_s = cand_s[IDX_W-1:0];
      if (!found_s && pndng[cand_idx_s]) begin
        found_s = 1'b1;
        win_s   = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Destination decode of the captured packet; unknown IDs are dropped
  always_comb begin
    dest_s      = data_q_r[PCKG_SZ-1 -: ID_W];
    dest_ext_s  = 32'(dest_s);
    push_mask_s = '0;
    drop_s      = 1'b0;
    if (dest_ext_s < 32'(DRVRS)) begin
      push_mask_s[dest_ext_s[IDX_W-1:0]] = 1'b1;
    end else if (dest_s == BROADCAST) begin
      push_mask_s = ~(ONE_HOT0 << win_r);
    end else begin
      drop_s = 1'b1;
    end
  end

  // Pointer moves one past the winner, wrapping at the last device
  always_comb begin
    if (win_r == IDX_W'(DRVRS - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = win_r + IDX_W'(1);
    end
  end

  // Arbitration FSM with registered strobes, bus data and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      win_r      <= '0;
      data_q_r   <= '0;
      pop_r      <= '0;
      push_r     <= '0;
      d_push_r   <= '0;
      busy_r     <= 1'b0;
      err_drop_r <= 1'b0;
`ifdef BUS_STATS_EN
      pkt_cnt_r  <= 32'd0;
`endif
    end else begin
      pop_r      <= '0;
      push_r     <= '0;
      err_drop_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|pndng) begin
            win_r   <= win_s;
            state_r <= POP;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        POP: begin
          // A source that withdrew its request is skipped without moving the pointer
          if (pndng[win_r]) begin
            pop_r    <= ONE_HOT0 << win_r;
            data_q_r <= D_pop[int'(win_r)*PCKG_SZ +: PCKG_SZ];
            state_r  <= PUSH;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
          end
        end
        PUSH: begin
          push_r     <= push_mask_s;
          d_push_r   <= data_q_r;
          err_drop_r <= drop_s;
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          if (ARB_MODE == 0) begin
            rr_ptr_r <= next_ptr_s;
          end else begin
            rr_ptr_r <= rr_ptr_r;
          end
`ifdef BUS_STATS_EN
          if (|push_mask_s) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
          end else begin
            pkt_cnt_r <= pkt_cnt_r;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pop      = pop_r;
  assign push     = push_r;
  assign D_push   = d_push_r;
  assign busy     = busy_r;
  assign err_drop = err_drop_r;
`ifdef BUS_STATS_EN
  assign pkt_cnt  = pkt_cnt_r;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: a round-robin and a fixed-priority instance share one stimulus.
module tb_bus_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  pndng;
  logic [95:0] d_pop;
  logic [5:0]  pop_rr, push_rr, pop_fp, push_fp;
  logic [15:0] d_push_rr, d_push_fp;
  logic        busy_rr, busy_fp, err_rr, err_fp;
`ifdef BUS_STATS_EN
  logic [31:0] cnt_rr, cnt_fp;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
    .pop(pop_rr), .push(push_rr), .D_push(d_push_rr), .busy(busy_rr),
`ifdef BUS_STATS_EN
    .pkt_cnt(cnt_rr),
`endif
    .err_drop(err_rr)
  );

  bus_rr_arbiter #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
    .pop(pop_fp), .push(push_fp), .D_push(d_push_fp), .busy(busy_fp),
`ifdef BUS_STATS_EN
    .pkt_cnt(cnt_fp),
`endif
    .err_drop(err_fp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [5:0] rr_order [7];

  initial begin
    rr_order = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
    reset = 1'b0;
    pndng = 6'h3F;
    d_pop = '0;
    #1;

    // Reset held two cycles with every device requesting
    tick(); tick();
    chk("rst_pop",  32'(pop_rr),  32'h0);
    chk("rst_push", 32'(push_rr), 32'h0);
    chk("rst_busy", 32'(busy_rr), 32'h0);
    chk("rst_err",  32'(err_rr),  32'h0);
`ifdef BUS_STATS_EN
    chk("rst_cnt", cnt_rr, 32'd0);
`endif

    // Unicast from device 1 to device 3
    reset = 1'b1;
    pndng = 6'b000010;
    d_pop[1*16 +: 16] = 16'h0342;
    tick();
    chk("uc_busy_pop_state", 32'(busy_rr), 32'h1);
    chk("uc_nopop_early", 32'(pop_rr), 32'h0);
    tick();
    chk("uc_pop", 32'(pop_rr), 32'h02);
    chk("uc_nopush_with_pop", 32'(push_rr), 32'h0);
    pndng = 6'b000000;
    tick();
    chk("uc_push",  32'(push_rr),  32'h08);
    chk("uc_data",  32'(d_push_rr), 32'h0342);
    chk("uc_popoff", 32'(pop_rr),  32'h0);
    chk("uc_busy_idle", 32'(busy_rr), 32'h0);
`ifdef BUS_STATS_EN
    chk("uc_cnt", cnt_rr, 32'd1);
`endif

    // Broadcast from device 2
    pndng = 6'b000100;
    d_pop[2*16 +: 16] = 16'hFFAA;
    tick(); tick();
    chk("bc_pop", 32'(pop_rr), 32'h04);
    pndng = 6'b000000;
    tick();
    chk("bc_push", 32'(push_rr),   32'h3B);
    chk("bc_data", 32'(d_push_rr), 32'hFFAA);
`ifdef BUS_STATS_EN
    chk("bc_cnt", cnt_rr, 32'd2);
`endif

    // Invalid destination 0x09 from device 0
    pndng = 6'b000001;
    d_pop[0*16 +: 16] = 16'h0911;
    tick(); tick();
    chk("bad_pop", 32'(pop_rr), 32'h01);
    pndng = 6'b000000;
    tick();
    chk("bad_push", 32'(push_rr), 32'h0);
    chk("bad_err",  32'(err_rr),  32'h1);
`ifdef BUS_STATS_EN
    chk("bad_cnt", cnt_rr, 32'd2);
`endif
    tick();
    chk("bad_err_pulse", 32'(err_rr), 32'h0);

    // Fairness: all devices requesting, every packet addressed to device 0
    reset = 1'b0;
    d_pop = '0;
    tick();
    reset = 1'b1;
    pndng = 6'h3F;
    for (int k = 0; k < 7; k++) begin
      tick(); tick();
      chk($sformatf("rr_pop%0d", k), 32'(pop_rr), 32'(rr_order[k]));
      chk($sformatf("fp_pop%0d", k), 32'(pop_fp), 32'h01);
      tick();
      chk($sformatf("rr_push%0d", k), 32'(push_rr), 32'h01);
    end
`ifdef BUS_STATS_EN
    chk("rr_cnt7", cnt_rr, 32'd7);
`endif

    // Reset asserted during PUSH aborts the transfer and clears the pointer
    tick(); tick();
    chk("mid_pop", 32'(pop_rr), 32'h02);
    reset = 1'b0;
    tick();
    chk("mid_push", 32'(push_rr), 32'h0);
    chk("mid_busy", 32'(busy_rr), 32'h0);
`ifdef BUS_STATS_EN
    chk("mid_cnt", cnt_rr, 32'd0);
`endif
    reset = 1'b1;
    tick(); tick();
    chk("mid_ptr0", 32'(pop_rr), 32'h01);
    tick();

    // Withdrawal in POP: no pop, back to IDLE, pointer stays at 1
    pndng = 6'b010000;
    tick();
    pndng = 6'b000000;
    tick();
    chk("wd_nopop", 32'(pop_rr),  32'h0);
    chk("wd_busy",  32'(busy_rr), 32'h0);
    tick();
    chk("wd_nopush", 32'(push_rr), 32'h0);
    pndng = 6'h3F;
    tick(); tick();
    chk("wd_ptr_kept", 32'(pop_rr), 32'h02);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
